// File: rtl/div.sv
// Sequential unsigned restoring divider (WIDTH/WIDTH -> quotient, remainder) that
// borrows a shared 2*WIDTH-bit adder. Define DIV_EARLY_EXIT_EN to finish a_i<b_i in IDLE.
module div #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   sum_in_a,
  output logic [2*WIDTH-1:0]   sum_in_b,
  input  logic [2*WIDTH-1:0]   sum_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   nb_q, nb_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     qw_q, qw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH:0]       s_s;
  logic                 early_s;

  // Partial remainder is always < B < 2^WIDTH, so its top bit is never set
  // and R is held in WIDTH bits; S still carries the full WIDTH+1 bits.
  assign s_s = {r_q, qw_q[WIDTH-1]};

`ifdef DIV_EARLY_EXIT_EN
  assign early_s = (a_i < b_i);
`else
  assign early_s = 1'b0;
`endif

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      nb_q    <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      nb_q    <= nb_d;
      r_q     <= r_d;
      qw_q    <= qw_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    nb_d    = nb_q;
    r_d     = r_q;
    qw_d    = qw_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b_i == '0) begin
            quot_d = '1;
            rem_d  = a_i;
            dbz_d  = 1'b1;
          end else if (early_s) begin
            quot_d = '0;
            rem_d  = a_i;
            dbz_d  = 1'b0;
          end else begin
            // Dividend goes straight into the quotient shift register
            qw_d    = a_i;
            b_d     = b_i;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_NEG;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NEG: begin
        nb_d    = sum_out;
        r_d     = '0;
        cnt_d   = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (sum_out[2*WIDTH-1] == 1'b0) begin
          r_d  = sum_out[WIDTH-1:0];
          qw_d = {qw_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d  = s_s[WIDTH-1:0];
          qw_d = {qw_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          quot_d  = qw_d;
          rem_d   = r_d;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_STEP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shared adder operands: -B in NEG, S + (-B) trial subtract in STEP
  always_comb begin
    sum_in_a = '0;
    sum_in_b = '0;
    case (state_q)
      S_NEG: begin
        sum_in_a = ~{{WIDTH{1'b0}}, b_q};
        sum_in_b = {{(2*WIDTH-1){1'b0}}, 1'b1};
      end
      S_STEP: begin
        sum_in_a = {{(WIDTH-1){1'b0}}, s_s};
        sum_in_b = nb_q;
      end
      default: begin
        sum_in_a = '0;
        sum_in_b = '0;
      end
    endcase
  end

endmodule
